// File: rtl/alu_rr_scheduler.sv
// Round-robin front end for one shared combinational ALU: grants one requester,
// registers its operands into the ALU, captures the result and returns it with the ID.
module alu_rr_scheduler #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*3-1:0] req_a,
  input  logic [N_REQ*3-1:0] req_b,
  input  logic [N_REQ*4-1:0] req_op,
  output logic [2:0]         alu_a,
  output logic [2:0]         alu_b,
  output logic [3:0]         alu_sel_op,
  input  logic [5:0]         alu_result,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [ID_W-1:0]    rsp_id,
  output logic [5:0]         rsp_result,
  output logic               rsp_err,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state_reg, state_next;
  logic [ID_W-1:0] rr_ptr_reg, rr_ptr_next;
  logic [2:0]      alu_a_reg, alu_b_reg;
  logic [3:0]      alu_sel_op_reg;
  logic [ID_W-1:0] rsp_id_reg;
  logic [5:0]      rsp_result_reg;
  logic            rsp_err_reg;

  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] idx_sel;
  int              idx_full;
  int              ptr_full;
  logic            accept;

  logic [2:0] a_arr  [N_REQ];
  logic [2:0] b_arr  [N_REQ];
  logic [3:0] op_arr [N_REQ];

  assign accept = (state_reg == IDLE) && grant_found;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
      assign a_arr[gi]  = req_a[3*gi +: 3];
      assign b_arr[gi]  = req_b[3*gi +: 3];
      assign op_arr[gi] = req_op[4*gi +: 4];
      // Gated by rst_n so no ready leaks out while reset is held.
      assign req_ready[gi] = rst_n && accept && (grant_idx == ID_W'(gi));
    end
  endgenerate

  // First valid requester at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    idx_full    = 0;
    idx_sel     = '0;
    ptr_full    = 0;
    rr_ptr_next = rr_ptr_reg;
    for (int k = 0; k < N_REQ; k++) begin
      idx_full = (int'(rr_ptr_reg) + k) % N_REQ;
      idx_sel  = idx_full[ID_W-1:0];
      if (!grant_found && req_valid[idx_sel]) begin
        grant_found = 1'b1;
        grant_idx   = idx_sel;
      end
    end
    if (grant_found) begin
      ptr_full    = (int'(grant_idx) + 1) % N_REQ;
      rr_ptr_next = ptr_full[ID_W-1:0];
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_found) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg     <= '0;
      alu_a_reg      <= '0;
      alu_b_reg      <= '0;
      alu_sel_op_reg <= '0;
      rsp_id_reg     <= '0;
      rsp_result_reg <= '0;
      rsp_err_reg    <= 1'b0;
    end else begin
      if (accept) begin
        alu_a_reg      <= a_arr[grant_idx];
        alu_b_reg      <= b_arr[grant_idx];
        alu_sel_op_reg <= op_arr[grant_idx];
        rsp_id_reg     <= grant_idx;
        rr_ptr_reg     <= rr_ptr_next;
      end
      if (state_reg == EXEC) begin
        rsp_result_reg <= alu_result;
        rsp_err_reg    <= (alu_sel_op_reg == 4'b0100) && (alu_b_reg == 3'd0);
      end
    end
  end

  assign alu_a      = alu_a_reg;
  assign alu_b      = alu_b_reg;
  assign alu_sel_op = alu_sel_op_reg;
  assign rsp_id     = rsp_id_reg;
  assign rsp_result = rsp_result_reg;
  assign rsp_err    = rsp_err_reg;
  assign rsp_valid  = (state_reg == RESP);
  assign busy       = (state_reg != IDLE);

endmodule
